// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle between the execute stage and alu_mc
// Ports: in_valid/in_ready/A/B/ALUControl carry the request; out_valid/out_ready/Result/Z/N/V/C carry the result; busy flags a multi-cycle op
interface alu_mc_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALUControl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             Z;
   logic             N;
   logic             V;
   logic             C;
   logic             busy;
   modport master (
      output in_valid, A, B, ALUControl, out_ready,
      input  in_ready, out_valid, Result, Z, N, V, C, busy
   );
   modport slave (
      input  in_valid, A, B, ALUControl, out_ready,
      output in_ready, out_valid, Result, Z, N, V, C, busy
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (add/sub/logic/compare/shift, iterative mul/mulhu/divu/remu) with registered Result and Z/N/V/C
// Ports: clk; rst (synchronous, active low); bus (alu_mc_if.slave) carrying the request, result and busy signals
// Option: ALU_MULDIV_EN builds the iterative multiply/divide; without it opcodes 1010-1101 return 0 with flags 0 in one cycle
module alu_mc #(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input logic     clk,
   input logic     rst,
   alu_mc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t           r_state;
   logic             r_out_valid;
   logic             r_z;
   logic             r_n;
   logic             r_v;
   logic             r_c;
   logic [WIDTH-1:0] r_result;
   logic             w_accept;
   logic             w_sub;
   logic             w_arith;
   logic             w_zn;
   logic             w_v;
   logic             w_c;
   logic [WIDTH-1:0] w_bop;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH:0]   w_sum;
   logic [SHW-1:0]   w_sh;
   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_sub    = bus.ALUControl == 4'b0001;
   assign w_arith  = bus.ALUControl[3:1] == 3'b000;
   // Z/N are only meaningful for ops 0000-1001; everything above that reaching this path returns all-zero flags
   assign w_zn     = bus.ALUControl <= 4'd9;
   assign w_bop    = w_sub ? ~bus.B : bus.B;
   assign w_sum    = {1'b0, bus.A} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};
   assign w_sh     = bus.B[SHW-1:0];
   assign w_c      = w_arith && w_sum[WIDTH];
   assign w_v      = w_arith && (bus.A[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
   always_comb begin
      case (bus.ALUControl)
         4'b0000, 4'b0001: w_res = w_sum[WIDTH-1:0];
         4'b0010:          w_res = bus.A & bus.B;
         4'b0011:          w_res = bus.A | bus.B;
         4'b0100:          w_res = bus.A ^ bus.B;
         4'b0101:          w_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
         4'b0110:          w_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
         4'b0111:          w_res = bus.A << w_sh;
         4'b1000:          w_res = bus.A >> w_sh;
         4'b1001:          w_res = $signed(bus.A) >>> w_sh;
         default:          w_res = '0;
      endcase
   end
`ifdef ALU_MULDIV_EN
   logic [SHW-1:0]     r_cnt;
   logic               r_busy;
   logic               r_sel;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic               w_is_mul;
   logic               w_is_div;
   logic [WIDTH:0]     w_madd;
   logic [WIDTH:0]     w_rsh;
   logic [WIDTH-1:0]   w_dif;
   logic [2*WIDTH-1:0] w_acc_nx;
   logic [WIDTH-1:0]   w_fin;
   assign w_is_mul = bus.ALUControl[3:1] == 3'b101;
   assign w_is_div = bus.ALUControl[3:1] == 3'b110;
   // MUL: add multiplicand into the upper half when the multiplier LSB is set, then shift the whole accumulator right
   assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b[0] ? r_a : {WIDTH{1'b0}}};
   // DIV: upper half is the remainder, lower half shifts the dividend out MSB first and the quotient in LSB first
   assign w_rsh    = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_dif    = w_rsh[WIDTH-1:0] - r_b;
   assign w_acc_nx = (r_state == MUL) ? {w_madd, r_acc[WIDTH-1:1]}
                   : (w_rsh >= {1'b0, r_b}) ? {w_dif, r_acc[WIDTH-2:0], 1'b1}
                   : {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
   // r_sel picks mulhu/remu (upper half) over mul/divu (lower half)
   assign w_fin    = r_sel ? w_acc_nx[2*WIDTH-1:WIDTH] : w_acc_nx[WIDTH-1:0];
   assign bus.busy = r_busy;
`else
   assign bus.busy = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
         r_v         <= 1'b0;
         r_c         <= 1'b0;
`ifdef ALU_MULDIV_EN
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_sel       <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
`endif
      end else begin
         if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
`ifdef ALU_MULDIV_EN
               if (w_is_mul || w_is_div) begin
                  r_state <= w_is_mul ? MUL : DIV;
                  r_busy  <= 1'b1;
                  r_cnt   <= SHW'(WIDTH - 1);
                  r_sel   <= bus.ALUControl[0];
                  r_a     <= bus.A;
                  r_b     <= bus.B;
                  r_acc   <= w_is_mul ? '0 : {{WIDTH{1'b0}}, bus.A};
               end else
`endif
               begin
                  r_out_valid <= 1'b1;
                  r_result    <= w_res;
                  r_z         <= w_zn && (w_res == '0);
                  r_n         <= w_zn && w_res[WIDTH-1];
                  r_v         <= w_v;
                  r_c         <= w_c;
               end
            end
`ifdef ALU_MULDIV_EN
            MUL, DIV: begin
               r_acc <= w_acc_nx;
               if (r_state == MUL) r_b <= r_b >> 1;
               if (r_cnt == '0) begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_result    <= w_fin;
                  r_z         <= w_fin == '0;
                  r_n         <= w_fin[WIDTH-1];
                  r_v         <= 1'b0;
                  r_c         <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.in_ready  = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
   assign bus.out_valid = r_out_valid;
   assign bus.Result    = r_result;
   assign bus.Z         = r_z;
   assign bus.N         = r_n;
   assign bus.V         = r_v;
   assign bus.C         = r_c;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc at WIDTH = 32 (mul/div expectations follow ALU_MULDIV_EN)
module tb_alu_mc;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   alu_mc_if #(.WIDTH(32)) bus ();
   alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // flags packed as {Z,N,V,C}; latency counts the accepting edge as cycle 1
   task automatic run(input string tag, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic [3:0] exp_f, input int exp_lat);
      int lat;
      int nb;
      bus.ALUControl = opc;
      bus.A          = a;
      bus.B          = b;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      nb  = 0;
      while (!bus.out_valid && lat < 100) begin
         nb += (bus.busy && !bus.in_ready) ? 1 : 0;
         bus.A = ~bus.A;
         bus.B = bus.B ^ 32'h5;
         tick();
         lat++;
      end
      chk({tag, "/result"}, bus.Result, exp_r);
      chk({tag, "/flags"}, {28'd0, bus.Z, bus.N, bus.V, bus.C}, {28'd0, exp_f});
      chk({tag, "/latency"}, lat, exp_lat);
      chk({tag, "/busy_cycles"}, nb, exp_lat - 1);
   endtask
   initial begin
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      bus.A          = '0;
      bus.B          = '0;
      bus.ALUControl = '0;
      tick();
      tick();
      chk("reset/out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset/result", bus.Result, 32'd0);
      chk("reset/flags_busy", {27'd0, bus.Z, bus.N, bus.V, bus.C, bus.busy}, 32'd0);
      rst = 1'b1;
      #1;
      chk("reset/in_ready", {31'd0, bus.in_ready}, 32'd1);
      run("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110, 1);
      run("sub_eq", 4'b0001, 32'd5, 32'd5, 32'd0, 4'b1001, 1);
      run("sltu", 4'b0110, 32'd1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 1);
      run("slt", 4'b0101, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1000, 1);
      run("sra", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0100, 1);
      run("and", 4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100, 1);
      run("or", 4'b0011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000, 1);
      run("xor", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b1000, 1);
      run("sll31", 4'b0111, 32'd1, 32'd31, 32'h8000_0000, 4'b0100, 1);
      run("srl_amt_mask", 4'b1000, 32'h8000_0000, 32'd35, 32'h1000_0000, 4'b0000, 1);
      run("add_carry", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1001, 1);
      run("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011, 1);
      run("op1110", 4'b1110, 32'd5, 32'd5, 32'd0, 4'b0000, 1);
      run("op1111", 4'b1111, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'b0000, 1);
`ifdef ALU_MULDIV_EN
      run("mul", 4'b1010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b0100, 33);
      run("mulhu", 4'b1011, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0000, 33);
      run("divu", 4'b1100, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
      run("remu", 4'b1101, 32'd100, 32'd7, 32'd2, 4'b0000, 33);
      run("divu_by0", 4'b1100, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'b0100, 33);
      run("remu_by0", 4'b1101, 32'd7, 32'd0, 32'd7, 4'b0000, 33);
`else
      run("mul_off", 4'b1010, 32'd3, 32'd4, 32'd0, 4'b0000, 1);
      run("divu_off", 4'b1100, 32'd100, 32'd7, 32'd0, 4'b0000, 1);
`endif
      tick();
      bus.out_ready = 1'b0;
      run("hold_add", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
      bus.ALUControl = 4'b0000;
      bus.A          = 32'd10;
      bus.B          = 32'd20;
      bus.in_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold/result", bus.Result, 32'd5);
         chk("hold/hs", {27'd0, bus.in_ready, bus.out_valid, bus.Z, bus.N, bus.C}, 32'b01000);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("swap/in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("swap/result", bus.Result, 32'd30);
      chk("swap/out_valid", {31'd0, bus.out_valid}, 32'd1);
      tick();
      chk("retain/result", bus.Result, 32'd30);
      chk("retain/out_valid", {31'd0, bus.out_valid}, 32'd0);
      bus.ALUControl = 4'b1010;
      bus.A          = 32'hFFFF_FFFF;
      bus.B          = 32'd2;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (9) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort/state", {28'd0, bus.out_valid, bus.busy, bus.in_ready, bus.Z}, 32'b0010);
      chk("abort/result", bus.Result, 32'd0);
      repeat (40) tick();
      chk("abort/no_partial", {31'd0, bus.out_valid}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the pipelined RISC-V core's execute stage. It is the successor to the single-cycle 32-bit ALU. It adds XOR, unsigned compare, shifts and iterative multiply/divide (RV32M subset). It sits behind a valid/ready handshake so the hazard unit can stall on long operations. Results and Z/N/V/C flags are registered and held until consumed.

## Interface
Parameters:
- WIDTH, 32 — datapath width; power of two, ≥ 8.
- SHW, $clog2(WIDTH) — shift-amount width, derived; do not override.

Ports:
- clk  in  1 — single clock; all state on rising edge.
- rst  in  1 — synchronous, active-low reset.
- in_valid  in  1 — operation request.
- in_ready  out  1 — block accepts the request this cycle.
- A, B  in  WIDTH — operands.
- ALUControl  in  4 — operation code.
- out_valid  out  1 — Result/flags valid.
- out_ready  in  1 — consumer takes the result this cycle.
- Result  out  WIDTH — registered result.
- Z, N, V, C  out  1 each — registered zero, negative, overflow and carry flags.
- busy  out  1 — multi-cycle operation in progress.

## Operation
- Opcodes:
  - 0000 add; 0001 sub (A + ~B + 1); 0010 and; 0011 or; 0100 xor.
  - 0101 slt (signed); 0110 sltu.
  - 0111 sll; 1000 srl; 1001 sra. Shift amount is B[SHW-1:0].
  - 1010 mul (low WIDTH bits); 1011 mulhu (high WIDTH bits, unsigned).
  - 1100 divu; 1101 remu.
  - 1110 and 1111 give Result = 0 and all flags 0, with single-cycle latency.
- Handshake:
  - A transfer occurs when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - The output is consumed when out_valid && out_ready.
  - A new single-cycle result may load on the same edge the old result is consumed.
- FSM states: IDLE, MUL, DIV.
  - IDLE, accept single-cycle op: compute combinationally, load output register, stay in IDLE.
  - IDLE, accept mul/mulhu: latch operands and op, clear the 2·WIDTH accumulator, cnt = WIDTH−1, go to MUL.
  - IDLE, accept divu/remu: latch operands and op, clear the remainder, cnt = WIDTH−1, go to DIV.
  - MUL: one shift-add step per cycle (unsigned, multiplier LSB first).
  - DIV: one restoring step per cycle (quotient MSB first).
  - MUL/DIV with cnt == 0: load output register with the selected half or quotient/remainder, go to IDLE. Otherwise cnt−1.
- Divide by zero: quotient all ones; remainder = A. No trap and no extra cycles.
- Flags:
  - Z = (Result == 0) and N = Result[WIDTH−1], for every op except 1110/1111.
  - add/sub: C = carry-out of the WIDTH-bit sum; V = signed overflow (operand signs agree after B inversion and the sum sign differs).
  - C = V = 0 for all other ops.
- in_valid while in_ready is low is ignored. The requester must hold its request.
- Operands are latched at acceptance. A/B changes during MUL/DIV have no effect.

## Timing
- Reset (rst low at an edge): state = IDLE, cnt = 0, out_valid = 0, Result = 0, Z = N = V = C = 0, busy = 0. in_ready is 1 on the first cycle after reset.
- Reset mid-operation aborts the operation. No partial result is ever presented.
- Single-cycle op accepted at edge t: out_valid = 1 after edge t. Latency 1.
- mul/div accepted at edge t: busy = 1 from t+1 through t+WIDTH; out_valid = 1 after edge t+WIDTH. Latency WIDTH+1 (33 for WIDTH = 32).
- in_ready is 0 throughout MUL/DIV.
- out_valid with out_ready = 0: Result and flags stay stable, and in_ready = 0.
- Result and flags change only on an output-register load. They retain their value after consumption, with out_valid = 0.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIV states, counter, accumulator and opcodes 1010–1101 are built as specified.
- ALU_MULDIV_EN undefined:
  - Opcodes 1010–1101 behave as 1110 (Result 0, flags 0, latency 1).
  - FSM reduces to IDLE and busy is tied to 0.
  - All other behaviour is unchanged.

## Test plan
All scenarios use WIDTH = 32.
- add A = 0x7FFFFFFF, B = 1 → Result 0x80000000, N = 1, V = 1, C = 0, Z = 0; out_valid one cycle after acceptance.
- sub A = 5, B = 5 → Result 0, Z = 1, C = 1, V = 0. sltu A = 1, B = 0xFFFFFFFF → 1; slt same operands → 0. sra A = 0x80000000, B = 4 → 0xF8000000.
- mul A = 0xFFFFFFFF, B = 2 → 0xFFFFFFFE; mulhu same operands → 1. out_valid exactly 33 cycles after acceptance, in_ready = 0 and busy = 1 in between; toggle A/B mid-op without effect.
- divu 100/7 → 14; remu → 2. divu 7/0 → 0xFFFFFFFF; remu 7/0 → 7. Latency 33 each.
- Hold out_ready = 0 for 5 cycles after an add result → Result/flags stable, in_ready = 0. Assert out_ready with a new add presented → old result consumed and new result loaded on the same edge.
- Drive rst low at iteration 10 of a mul → after that edge out_valid = 0, busy = 0, in_ready = 1, Result = 0. Without ALU_MULDIV_EN, mul 3×4 → Result 0, latency 1.
